// File: rtl/spi_master_frame_pkg.sv
// Shared state type, SPI mode constants and sizing helpers for spi_master_frame.
package spi_master_frame_pkg;

   localparam bit CPOL_DEFAULT = 1'b0;
   localparam bit CPHA         = 1'b0;

   typedef enum logic [3:0] {
      S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY, S_TX, S_RX, S_CS_HOLD, S_CS_GAP
   } state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned com_w, input int unsigned addr_w,
                                             input int unsigned data_w, input int unsigned dummy_w);
      return $clog2(max_u(max_u(com_w, addr_w), max_u(data_w, 32'd1 << dummy_w)) + 1);
   endfunction

endpackage

// File: rtl/spi_master_frame_sclk_gen.sv
// SCLK clock-enable divider: half-period ticks, leading/trailing edge strobes, sclk level.
module spi_sclk_gen #(
   parameter int unsigned CLK_DIV = 2,
   parameter bit          CPOL    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic en,
   output logic half_tick,
   output logic lead_tick,
   output logic trail_tick,
   output logic sclk
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_cnt;

   assign half_tick  = run && (div_cnt == DW'(CLK_DIV - 1));
   assign lead_tick  = half_tick && en && (sclk == CPOL);
   assign trail_tick = half_tick && en && (sclk != CPOL);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= '0;
         sclk    <= CPOL;
      end else begin
         div_cnt <= (!run || half_tick) ? '0 : div_cnt + 1'b1;
         sclk    <= en ? (half_tick ? ~sclk : sclk) : CPOL;
      end
   end

endmodule

// File: rtl/spi_master_frame.sv
// SPI flash master: one frame per request (command, optional address, dummy, TX, RX), CPHA 0.
module spi_master_frame
   import spi_master_frame_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 24,
   parameter int unsigned COM_W   = 8,
   parameter int unsigned DUMMY_W = 4,
   parameter int unsigned CLK_DIV = 2,
   parameter bit          CPOL    = CPOL_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [COM_W-1:0]            command,
   input  logic [ADDR_W-1:0]           address,
   input  logic [DATA_W-1:0]           data_in,
   input  logic                        has_addr,
   input  logic [DUMMY_W-1:0]          dummy_cycles,
   input  logic [$clog2(DATA_W+1)-1:0] tx_bits,
   input  logic [$clog2(DATA_W+1)-1:0] rx_bits,
   output logic [DATA_W-1:0]           data_out,
   output logic                        rvalid,
   output logic                        busy,
   output logic                        sclk,
   output logic                        ss,
   output logic                        mosi,
   input  logic                        miso
);

   localparam int unsigned LW = $clog2(DATA_W + 1);
   localparam int unsigned CW = cnt_width(COM_W, ADDR_W, DATA_W, DUMMY_W);
   localparam int unsigned SW = max_u(max_u(COM_W, ADDR_W), DATA_W);

   state_t              state;
   state_t              nxt_state;
   logic [CW-1:0]       bit_cnt, nxt_len;
   logic [SW-1:0]       tx_sh, nxt_word;
   logic [COM_W-1:0]    command_q;
   logic [ADDR_W-1:0]   address_q;
   logic [DATA_W-1:0]   data_q, rx_acc;
   logic                has_addr_q, rx_done;
   logic [DUMMY_W-1:0]  dummy_q;
   logic [LW-1:0]       tx_q, rx_q;
   logic                half_tick, lead_tick, trail_tick, bit_phase;

   assign bit_phase = state inside {S_CMD, S_ADDR, S_DUMMY, S_TX, S_RX};

   spi_sclk_gen #(.CLK_DIV(CLK_DIV), .CPOL(CPOL)) u_sclk_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (state != S_IDLE),
      .en         (bit_phase),
      .half_tick  (half_tick),
      .lead_tick  (lead_tick),
      .trail_tick (trail_tick),
      .sclk       (sclk)
   );

   // Next non-empty phase after the current one; empty phases fall through in the same cycle.
   always_comb begin
      nxt_state = S_CS_HOLD;
      nxt_len   = '0;
      nxt_word  = '0;
      if (state == S_CS_SETUP) begin
         nxt_state = S_CMD;
         nxt_len   = CW'(COM_W);
         nxt_word  = SW'(command_q) << (SW - COM_W);
      end else if (state == S_CMD && has_addr_q) begin
         nxt_state = S_ADDR;
         nxt_len   = CW'(ADDR_W);
         nxt_word  = SW'(address_q) << (SW - ADDR_W);
      end else if ((state inside {S_CMD, S_ADDR}) && dummy_q != '0) begin
         nxt_state = S_DUMMY;
         nxt_len   = CW'(dummy_q);
      end else if ((state inside {S_CMD, S_ADDR, S_DUMMY}) && tx_q != '0) begin
         nxt_state = S_TX;
         nxt_len   = CW'(tx_q);
         nxt_word  = SW'(data_q) << (SW - DATA_W);
      end else if ((state inside {S_CMD, S_ADDR, S_DUMMY, S_TX}) && rx_q != '0) begin
         nxt_state = S_RX;
         nxt_len   = CW'(rx_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cmd_ready  <= 1'b0;
         busy       <= 1'b0;
         ss         <= 1'b1;
         mosi       <= 1'b0;
         data_out   <= '0;
         rvalid     <= 1'b0;
         rx_done    <= 1'b0;
         rx_acc     <= '0;
         bit_cnt    <= '0;
         tx_sh      <= '0;
         command_q  <= '0;
         address_q  <= '0;
         data_q     <= '0;
         has_addr_q <= 1'b0;
         dummy_q    <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
      end else begin
         rvalid <= 1'b0;
         if (rx_done) begin
            data_out <= rx_acc;
            rvalid   <= 1'b1;
            rx_done  <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  command_q  <= command;
                  address_q  <= address;
                  data_q     <= data_in;
                  has_addr_q <= has_addr;
                  dummy_q    <= dummy_cycles;
                  tx_q       <= (tx_bits > LW'(DATA_W)) ? LW'(DATA_W) : tx_bits;
                  rx_q       <= (rx_bits > LW'(DATA_W)) ? LW'(DATA_W) : rx_bits;
                  rx_acc     <= '0;
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
                  ss         <= 1'b0;
                  state      <= S_CS_SETUP;
               end
            end
            S_CS_SETUP: if (half_tick) begin
               state   <= nxt_state;
               bit_cnt <= nxt_len;
               mosi    <= nxt_word[SW-1];
               tx_sh   <= nxt_word << 1;
            end
            S_CS_HOLD: if (half_tick) begin
               state <= S_CS_GAP;
               ss    <= 1'b1;
            end
            S_CS_GAP: if (half_tick) begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: begin
               if (lead_tick && state == S_RX) begin
                  rx_acc <= {rx_acc[DATA_W-2:0], miso};
                  if (bit_cnt == CW'(1)) rx_done <= 1'b1;
               end
               if (trail_tick) begin
                  if (bit_cnt == CW'(1)) begin
                     state   <= nxt_state;
                     bit_cnt <= nxt_len;
                     mosi    <= nxt_word[SW-1];
                     tx_sh   <= nxt_word << 1;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                     mosi    <= tx_sh[SW-1];
                     tx_sh   <= tx_sh << 1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_frame.sv
// Self-checking bench for spi_master_frame with a behavioural SPI slave and frame model.
module tb_spi_master_frame;

   localparam int unsigned CLK_DIV = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  command = '0;
   logic [23:0] address = '0;
   logic [31:0] data_in = '0;
   logic        has_addr = 1'b0;
   logic [3:0]  dummy_cycles = '0;
   logic [5:0]  tx_bits = '0;
   logic [5:0]  rx_bits = '0;
   logic [31:0] data_out;
   logic        rvalid, busy, sclk, ss, mosi;
   logic        miso = 1'b0;

   spi_master_frame #(
      .DATA_W(32), .ADDR_W(24), .COM_W(8), .DUMMY_W(4), .CLK_DIV(CLK_DIV), .CPOL(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .command(command), .address(address), .data_in(data_in), .has_addr(has_addr),
      .dummy_cycles(dummy_cycles), .tx_bits(tx_bits), .rx_bits(rx_bits),
      .data_out(data_out), .rvalid(rvalid), .busy(busy),
      .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   int   n_pass = 0, n_total = 0, n_fail = 0;
   int   sclk_cnt = 0, ss_viol = 0, lead_n = 0;
   int   ss_low_clks = 0, rvalid_cnt = 0, accept_cnt = 0;
   logic mosi_cap [$];
   logic slave_bits [0:255];
   logic ss_d = 1'b1, sclk_d = 1'b0;
   logic [31:0] model_rx = '0;

   // SPI slave: presents bit 0 when ss falls, advances on each falling sclk, records MOSI on rising sclk.
   always @(ss or sclk) begin
      if (ss_d === 1'b1 && ss === 1'b0) begin
         lead_n = 0;
         miso = slave_bits[0];
      end
      if (sclk_d === 1'b0 && sclk === 1'b1) begin
         sclk_cnt++;
         mosi_cap.push_back(mosi);
         if (ss !== 1'b0) ss_viol++;
         lead_n++;
      end
      if (sclk_d === 1'b1 && sclk === 1'b0 && ss === 1'b0 && lead_n < 256) miso = slave_bits[lead_n];
      ss_d = ss;
      sclk_d = sclk;
   end

   always @(negedge clk) begin
      if (rst_n && ss === 1'b0) ss_low_clks++;
      if (rvalid === 1'b1) rvalid_cnt++;
   end

   always @(posedge clk) if (rst_n && cmd_valid && cmd_ready === 1'b1) accept_cnt++;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int w = 0;
      while (cmd_ready !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check({tag, ".ready"}, cmd_ready, 1'b1);
   endtask

   task automatic wait_idle(input string tag);
      int w = 0;
      while (busy !== 1'b0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      check({tag, ".done"}, busy, 1'b0);
   endtask

   task automatic scramble();
      command = 8'($urandom);
      address = 24'($urandom);
      data_in = $urandom;
      has_addr = 1'($urandom);
      dummy_cycles = 4'($urandom);
      tx_bits = 6'($urandom);
      rx_bits = 6'($urandom);
   endtask

   // Builds expected MOSI stream and slave response from the field rules, runs one frame, checks it.
   task automatic run_frame(input string tag, input logic [7:0] c, input logic [23:0] a,
                            input logic [31:0] d, input logic ha, input logic [3:0] dm,
                            input logic [5:0] tb, input logic [5:0] rb, input logic [31:0] sv);
      int tx_n, rx_n, pre, nbits, k, b_sclk, b_cap, b_ss, b_rv;
      logic [127:0] exp_m, obs_m;
      logic [63:0]  mask;
      tx_n = (tb > 6'd32) ? 32 : int'(tb);
      rx_n = (rb > 6'd32) ? 32 : int'(rb);
      pre = 8 + (ha ? 24 : 0) + int'(dm) + tx_n;
      nbits = pre + rx_n;
      exp_m = '0;
      k = 0;
      for (int i = 7; i >= 0; i--) begin exp_m[k] = c[i]; k = k + 1; end
      if (ha) for (int i = 23; i >= 0; i--) begin exp_m[k] = a[i]; k = k + 1; end
      k = k + int'(dm);
      for (int i = 0; i < tx_n; i++) begin exp_m[k] = d[31-i]; k = k + 1; end
      for (int j = 0; j < 256; j++) slave_bits[j] = 1'($urandom);
      for (int j = 0; j < rx_n; j++) slave_bits[pre+j] = sv[rx_n-1-j];
      if (rx_n > 0) begin
         mask = (64'd1 << rx_n) - 64'd1;
         model_rx = sv & mask[31:0];
      end

      wait_ready(tag);
      b_sclk = sclk_cnt;
      b_cap = mosi_cap.size();
      b_ss = ss_low_clks;
      b_rv = rvalid_cnt;
      command = c; address = a; data_in = d; has_addr = ha;
      dummy_cycles = dm; tx_bits = tb; rx_bits = rb;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      scramble();
      wait_idle(tag);
      repeat (3) @(negedge clk);

      obs_m = '0;
      for (int j = 0; j < pre; j++)
         if (b_cap + j < mosi_cap.size()) obs_m[j] = mosi_cap[b_cap+j];
      check({tag, ".sclks"}, sclk_cnt - b_sclk, nbits);
      check({tag, ".mosi"}, obs_m, exp_m);
      check({tag, ".rvalid_n"}, rvalid_cnt - b_rv, (rx_n > 0) ? 1 : 0);
      check({tag, ".data_out"}, data_out, model_rx);
      check({tag, ".ss_low"}, ss_low_clks - b_ss, 2 * CLK_DIV * nbits + 2 * CLK_DIV);
      check({tag, ".ss_held"}, ss_viol, 0);
   endtask

   initial begin
      int b_acc, b_sclk, b_rv, b_ss, w;

      repeat (3) @(negedge clk);
      check("rst.ss", ss, 1'b1);
      check("rst.sclk", sclk, 1'b0);
      check("rst.mosi", mosi, 1'b0);
      check("rst.data_out", data_out, 32'h0);
      check("rst.rvalid", rvalid, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.cmd_ready", cmd_ready, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst.ready_after", cmd_ready, 1'b1);

      run_frame("rdid",  8'h9F, 24'h0,      32'h0,         1'b0, 4'd0, 6'd0,  6'd24, 32'h00C22017);
      run_frame("read",  8'h03, 24'h123456, 32'h0,         1'b1, 4'd0, 6'd0,  6'd32, 32'hDEADBEEF);
      run_frame("prog",  8'h02, 24'h000100, 32'hA5A55A5A,  1'b1, 4'd0, 6'd32, 6'd0,  32'h12345678);
      run_frame("fread", 8'h0B, 24'h000000, 32'h0,         1'b1, 4'd8, 6'd0,  6'd8,  32'h0000003C);
      run_frame("wren",  8'h06, 24'h0,      32'h0,         1'b0, 4'd0, 6'd0,  6'd0,  32'h0);
      run_frame("clamp", 8'hC7, 24'hABCDEF, 32'h80000001,  1'b0, 4'd3, 6'd40, 6'd63, 32'hF00DCAFE);

      // cmd_valid held for 60 clk: long enough for exactly two 0x06 frames to be accepted
      wait_ready("hold");
      b_acc = accept_cnt; b_sclk = sclk_cnt; b_rv = rvalid_cnt; b_ss = ss_low_clks;
      command = 8'h06; has_addr = 1'b0; dummy_cycles = '0; tx_bits = '0; rx_bits = '0;
      cmd_valid = 1'b1;
      repeat (60) @(negedge clk);
      cmd_valid = 1'b0;
      wait_idle("hold");
      repeat (3) @(negedge clk);
      check("hold.accepts", accept_cnt - b_acc, 2);
      check("hold.sclks", sclk_cnt - b_sclk, 16);
      check("hold.rvalid_n", rvalid_cnt - b_rv, 0);
      check("hold.ss_low", ss_low_clks - b_ss, 2 * (2 * CLK_DIV * 8 + 2 * CLK_DIV));

      // Reset during bit 20 of a read
      for (int j = 0; j < 256; j++) slave_bits[j] = 1'($urandom);
      wait_ready("abort");
      b_sclk = sclk_cnt; b_rv = rvalid_cnt;
      command = 8'h03; address = 24'h654321; has_addr = 1'b1; rx_bits = 6'd32;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      w = 0;
      while (sclk_cnt - b_sclk < 20 && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("abort.reached_bit20", sclk_cnt - b_sclk, 20);
      check("abort.sclk_high", sclk, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort.ss", ss, 1'b1);
      check("abort.sclk", sclk, 1'b0);
      repeat (4) @(negedge clk);
      check("abort.busy", busy, 1'b0);
      check("abort.cmd_ready", cmd_ready, 1'b0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("abort.rvalid_n", rvalid_cnt - b_rv, 0);
      check("abort.data_out", data_out, 32'h0);
      model_rx = '0;
      run_frame("post_rst", 8'h03, 24'h000010, 32'h0, 1'b1, 4'd0, 6'd0, 6'd16, 32'h0000BEEF);

      for (int r = 0; r < 10; r++)
         run_frame("rand", 8'($urandom), 24'($urandom), $urandom, 1'($urandom),
                   4'($urandom_range(15, 0)), 6'($urandom_range(40, 0)),
                   6'($urandom_range(40, 0)), $urandom);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
